// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit
// ---------------------------------------------------------------------------
// Purpose:
//   Sits between the MIPS execute stage and a byte-addressed data memory.
//   Performs lb/lbu/lh/lhu/lw/sb/sh/sw. Sub-word stores are done as a
//   read-modify-write, because every memory write replaces a whole word.
//   Misaligned or out-of-range requests are rejected without touching memory.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   sig_req           start request, only looked at while idle
//   sig_we            1 = store, 0 = load
//   size              00 byte, 01 half, 10 word, 11 illegal
//   sig_unsigned      loads: 1 = zero-extend, 0 = sign-extend
//   addr              byte address of the access
//   store_data        store value, right-justified
//   load_data         extended load result, held until the next good load
//   sig_busy          high whenever the unit is not idle
//   sig_done          one-cycle pulse on successful completion
//   sig_misaligned    one-cycle pulse on a rejected request
//   mem_address       word-aligned memory address
//   mem_write_data    write word in memory byte order
//   sig_mem_read      memory read strobe
//   sig_mem_write     memory write strobe
//   mem_read_data     memory read word, valid while sig_mem_read is high
// ---------------------------------------------------------------------------
module mips_load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sig_req,
    input  logic        sig_we,
    input  logic [1:0]  size,
    input  logic        sig_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        sig_busy,
    output logic        sig_done,
    output logic        sig_misaligned,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] storeData_q, storeData_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] loadData_q, loadData_d;

    logic [2:0]  reqBytes;
    logic [32:0] reqEnd;
    logic        reqError;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] loadExt;
    logic [31:0] mergedSub;

    // Request checking on the live inputs, so the decision is made in the
    // same cycle the request is accepted. The end address is formed one bit
    // wider so that addresses near 2^32 cannot wrap into range.
    always_comb begin
        reqBytes = 3'd1;
        case (size)
            2'b01:   reqBytes = 3'd2;
            2'b10:   reqBytes = 3'd4;
            default: reqBytes = 3'd1;
        endcase
        reqEnd   = {1'b0, addr} + {30'd0, reqBytes};
        reqError = (size == 2'b11)
                 || (size == 2'b01 && addr[0])
                 || (size == 2'b10 && addr[1:0] != 2'b00)
                 || (reqEnd > 33'(MEM_BYTES));
    end

    // Big-endian view of the read word: byte offset 0 lives in [31:24].
    // Builds both the extended load value and the merged word for sb/sh.
    always_comb begin
        rdByte = 8'h00;
        case (addr_q[1:0])
            2'd0: rdByte = mem_read_data[31:24];
            2'd1: rdByte = mem_read_data[23:16];
            2'd2: rdByte = mem_read_data[15:8];
            2'd3: rdByte = mem_read_data[7:0];
        endcase
        rdHalf = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];

        loadExt = mem_read_data;
        if (size_q == 2'b00) begin
            loadExt = unsigned_q ? {24'd0, rdByte} : {{24{rdByte[7]}}, rdByte};
        end else if (size_q == 2'b01) begin
            loadExt = unsigned_q ? {16'd0, rdHalf} : {{16{rdHalf[15]}}, rdHalf};
        end

        mergedSub = mem_read_data;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: mergedSub[31:24] = storeData_q[7:0];
                2'd1: mergedSub[23:16] = storeData_q[7:0];
                2'd2: mergedSub[15:8]  = storeData_q[7:0];
                2'd3: mergedSub[7:0]   = storeData_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            mergedSub[15:0] = storeData_q[15:0];
        end else begin
            mergedSub[31:16] = storeData_q[15:0];
        end
    end

    // Next-state logic. Requests are only sampled in IDLE, so a request
    // arriving while busy is simply dropped. A full-word store skips the
    // read because it overwrites every byte anyway.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        unsigned_d  = unsigned_q;
        storeData_d = storeData_q;
        merged_d    = merged_q;
        loadData_d  = loadData_q;

        case (state_q)
            S_IDLE: begin
                if (sig_req) begin
                    addr_d      = addr;
                    size_d      = size;
                    we_d        = sig_we;
                    unsigned_d  = sig_unsigned;
                    storeData_d = store_data;
                    if (reqError) begin
                        state_d = S_ERR;
                    end else if (sig_we && size == 2'b10) begin
                        merged_d = store_data;
                        state_d  = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (we_q) begin
                    merged_d = mergedSub;
                    state_d  = S_WRITE;
                end else begin
                    loadData_d = loadExt;
                    state_d    = S_DONE;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            size_q      <= 2'd0;
            we_q        <= 1'b0;
            unsigned_q  <= 1'b0;
            storeData_q <= 32'd0;
            merged_q    <= 32'd0;
            loadData_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            unsigned_q  <= unsigned_d;
            storeData_q <= storeData_d;
            merged_q    <= merged_d;
            loadData_q  <= loadData_d;
        end
    end

    // Strobes are decoded straight from the state register so they drop
    // the instant reset forces the state back to IDLE. The memory stores
    // [7:0] at the lowest address, hence the byte swap on write data.
    assign sig_mem_read   = (state_q == S_READ);
    assign sig_mem_write  = (state_q == S_WRITE);
    assign sig_busy       = (state_q != S_IDLE);
    assign sig_done       = (state_q == S_DONE);
    assign sig_misaligned = (state_q == S_ERR);
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = {merged_q[7:0], merged_q[15:8], merged_q[23:16], merged_q[31:24]};
    assign load_data      = loadData_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// tb_mips_load_store_unit
// ---------------------------------------------------------------------------
// Self-checking bench: a byte-array data memory drives the DUT, while a
// separate byte-array reference model predicts memory contents, write words,
// load results, latencies and strobe counts from the architectural rules.
// ---------------------------------------------------------------------------
module tb_mips_load_store_unit;

    logic        clk;
    logic        reset;
    logic        sig_req;
    logic        sig_we;
    logic [1:0]  size;
    logic        sig_unsigned;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        sig_busy;
    logic        sig_done;
    logic        sig_misaligned;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] mem_read_data;

    logic [7:0]  mem    [0:1023];
    logic [7:0]  refMem [0:1023];
    logic [9:0]  memA;
    logic [31:0] expLoad;
    int          compared;
    int          mismatched;

    mips_load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .sig_req        (sig_req),
        .sig_we         (sig_we),
        .size           (size),
        .sig_unsigned   (sig_unsigned),
        .addr           (addr),
        .store_data     (store_data),
        .load_data      (load_data),
        .sig_busy       (sig_busy),
        .sig_done       (sig_done),
        .sig_misaligned (sig_misaligned),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .sig_mem_read   (sig_mem_read),
        .sig_mem_write  (sig_mem_write),
        .mem_read_data  (mem_read_data)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory read port: lowest address appears in [31:24].
    always_comb begin
        memA = {mem_address[9:2], 2'b00};
        mem_read_data = sig_mem_read ?
            {mem[memA], mem[memA | 10'd1], mem[memA | 10'd2], mem[memA | 10'd3]} : 32'h0;
    end

    // Data memory write port: [7:0] lands at the lowest address.
    always @(posedge clk) begin
        if (sig_mem_write) begin
            mem[{mem_address[9:2], 2'b00}]         <= mem_write_data[7:0];
            mem[{mem_address[9:2], 2'b00} | 10'd1] <= mem_write_data[15:8];
            mem[{mem_address[9:2], 2'b00} | 10'd2] <= mem_write_data[23:16];
            mem[{mem_address[9:2], 2'b00} | 10'd3] <= mem_write_data[31:24];
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Seed one byte in both the real memory and the reference model.
    task automatic setByte(input int a, input logic [7:0] v);
        mem[a]    = v;
        refMem[a] = v;
    endtask

    // Issue one request and follow it to completion, checking the strobes,
    // write word, latency, pulse shape and load result against the model.
    // With interfere set, a second store is presented while the unit is busy.
    task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] sd, input bit interfere);
        int          nBytes;
        bit          isErr;
        int          expLat;
        int          expReads;
        int          expWrites;
        int          cycles;
        int          reads;
        int          writes;
        bit          finished;
        int          base;
        int          off;
        logic [7:0]  nb [4];
        logic [31:0] expWd;
        logic [15:0] h;
        logic [7:0]  b;

        nBytes = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 1;
        isErr  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (longint'(a) + longint'(nBytes) > 64'd1024);
        expLat    = isErr ? 1 : (we && sz != 2'b10) ? 3 : 2;
        expReads  = (isErr || (we && sz == 2'b10)) ? 0 : 1;
        expWrites = (!isErr && we) ? 1 : 0;

        base  = isErr ? 0 : int'({a[9:2], 2'b00});
        off   = int'(a[1:0]);
        expWd = 32'h0;
        for (int i = 0; i < 4; i++) nb[i] = refMem[base + i];
        if (!isErr && we) begin
            if (sz == 2'b10) begin
                for (int i = 0; i < 4; i++) nb[i] = sd[31 - 8*i -: 8];
            end else if (sz == 2'b01) begin
                nb[off]     = sd[15:8];
                nb[off + 1] = sd[7:0];
            end else begin
                nb[off] = sd[7:0];
            end
            expWd = {nb[3], nb[2], nb[1], nb[0]};
        end

        @(negedge clk);
        sig_req      = 1'b1;
        sig_we       = we;
        size         = sz;
        sig_unsigned = uns;
        addr         = a;
        store_data   = sd;
        @(posedge clk);
        #1;
        sig_req  = 1'b0;
        cycles   = 1;
        reads    = 0;
        writes   = 0;
        finished = 0;
        while (!finished && cycles <= 6) begin
            checkOutput("strobe_exclusive", {31'd0, sig_mem_read & sig_mem_write}, 32'd0);
            if (sig_mem_read) begin
                reads++;
                checkOutput("read_addr", mem_address, {a[31:2], 2'b00});
            end
            if (sig_mem_write) begin
                writes++;
                checkOutput("write_addr", mem_address, {a[31:2], 2'b00});
                checkOutput("write_data", mem_write_data, expWd);
            end
            if (sig_done || sig_misaligned) begin
                finished = 1;
                sig_req  = 1'b0;
            end else begin
                checkOutput("busy_mid", {31'd0, sig_busy}, 32'd1);
                if (interfere && cycles == 1) begin
                    sig_req    = 1'b1;
                    sig_we     = 1'b1;
                    size       = 2'b10;
                    addr       = {a[31:2], 2'b00};
                    store_data = 32'hDEADBEEF;
                end
                @(posedge clk);
                #1;
                cycles++;
            end
        end
        sig_req = 1'b0;

        checkOutput("finished", {31'd0, finished}, 32'd1);
        checkOutput("latency", cycles, expLat);
        checkOutput("done_pulse", {31'd0, sig_done}, {31'd0, !isErr});
        checkOutput("misaligned_pulse", {31'd0, sig_misaligned}, {31'd0, isErr});
        checkOutput("busy_end", {31'd0, sig_busy}, 32'd1);
        checkOutput("read_count", reads, expReads);
        checkOutput("write_count", writes, expWrites);

        // Reference model update: memory for good stores, load_data for good loads.
        if (!isErr && we) begin
            for (int i = 0; i < 4; i++) refMem[base + i] = nb[i];
        end
        if (!isErr && !we) begin
            if (sz == 2'b00) begin
                b       = refMem[int'(a[9:0])];
                expLoad = uns ? {24'd0, b} : {{24{b[7]}}, b};
            end else if (sz == 2'b01) begin
                h       = {refMem[int'(a[9:0])], refMem[int'(a[9:0]) + 1]};
                expLoad = uns ? {16'd0, h} : {{16{h[15]}}, h};
            end else begin
                expLoad = {refMem[base], refMem[base + 1], refMem[base + 2], refMem[base + 3]};
            end
        end
        checkOutput("load_data", load_data, expLoad);

        @(posedge clk);
        #1;
        checkOutput("back_to_idle", {29'd0, sig_done, sig_misaligned, sig_busy}, 32'd0);
        if (!isErr) begin
            checkOutput("mem_word", {mem[base], mem[base + 1], mem[base + 2], mem[base + 3]},
                        {refMem[base], refMem[base + 1], refMem[base + 2], refMem[base + 3]});
        end
    endtask

    // Reset arriving while a halfword store sits in READ: strobes must fall
    // immediately, no write may follow, and memory must be left alone.
    task automatic applyResetMidRead();
        @(negedge clk);
        sig_req      = 1'b1;
        sig_we       = 1'b1;
        size         = 2'b01;
        sig_unsigned = 1'b0;
        addr         = 32'h20;
        store_data   = 32'h0000BEEF;
        @(posedge clk);
        #1;
        sig_req = 1'b0;
        checkOutput("rst_pre_read", {31'd0, sig_mem_read}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_strobes", {30'd0, sig_mem_read, sig_mem_write}, 32'd0);
        checkOutput("rst_busy", {31'd0, sig_busy}, 32'd0);
        checkOutput("rst_load_data", load_data, 32'd0);
        expLoad = 32'd0;
        @(posedge clk);
        #1;
        checkOutput("rst_no_write", {31'd0, sig_mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_word", {mem[32], mem[33], mem[34], mem[35]},
                    {refMem[32], refMem[33], refMem[34], refMem[35]});
    endtask

    // Main sequence: reset, directed cases, then randomized traffic.
    initial begin
        int          diffs;
        int          r;
        logic [31:0] ra;
        logic [1:0]  rs;

        compared     = 0;
        mismatched   = 0;
        expLoad      = 32'd0;
        reset        = 1'b1;
        sig_req      = 1'b0;
        sig_we       = 1'b0;
        size         = 2'b00;
        sig_unsigned = 1'b0;
        addr         = 32'd0;
        store_data   = 32'd0;
        for (int i = 0; i < 1024; i++) setByte(i, 8'($urandom));
        setByte(16, 8'h11);
        setByte(17, 8'h22);
        setByte(18, 8'h33);
        setByte(19, 8'h44);
        setByte(20, 8'h80);
        setByte(21, 8'h01);

        #12;
        checkOutput("reset_outputs",
                    {26'd0, sig_busy, sig_done, sig_misaligned, sig_mem_read, sig_mem_write, 1'b0}, 32'd0);
        checkOutput("reset_load_data", load_data, 32'd0);
        checkOutput("reset_mem_address", mem_address, 32'd0);
        checkOutput("reset_write_data", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        checkOutput("tp_lw", load_data, 32'h11223344);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
        checkOutput("tp_lw_after_sb", load_data, 32'h1122AB44);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h14, 32'h0, 0);
        checkOutput("tp_lh", load_data, 32'hFFFF8001);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 0);
        checkOutput("tp_lhu", load_data, 32'h00008001);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, 0);
        checkOutput("tp_lb", load_data, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, 0);
        checkOutput("tp_lbu", load_data, 32'h00000001);

        applyStimulus(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h12345678, 0);
        checkOutput("tp_err_load_kept", load_data, 32'h00000001);

        applyStimulus(1'b1, 2'b00, 1'b0, 32'h19, 32'h0000005A, 1);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, 0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h3FE, 32'h00001234, 0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 0);

        applyResetMidRead();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0)      ra = $urandom;
            else if (r < 5)  ra = 32'($urandom_range(1016, 1023));
            else             ra = 32'($urandom_range(0, 1023));
            rs = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0) begin
                if (rs == 2'b10) ra[1:0] = 2'b00;
                if (rs == 2'b01) ra[0]   = 1'b0;
            end
            applyStimulus(1'($urandom), rs, 1'($urandom), ra, $urandom, ($urandom_range(0, 7) == 0));
        end

        diffs = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== refMem[i]) diffs++;
        checkOutput("mem_sweep_diffs", diffs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
